rx_udp: RTL
===========

# rx_udp

UDP receive stage that sits directly downstream of the IPv4 receive stage and consumes its `rx_data_udp`/`rx_data` byte stream. It parses the 8-byte UDP header, filters on a programmed destination port, and forwards payload bytes as a valid/last stream trimmed to the UDP length field. The IRQ chain is extended by one registered stage.

## Interface
- `OCT`, default 8: byte width.
- `RX_CLK` input, 1 bit: receive clock; all logic is on its rising edge.
- `rst` input, 1 bit: reset, synchronous and active-high.
- `func_en` input, 1 bit: block enable.
- `udp_port` input, 16 bits: accepted destination port. `16'h0000` accepts any port.
- `rx_ipv4_irq` input, 1 bit: IRQ from the IPv4 stage.
- `rx_udp_irq` output, 1 bit: `rx_ipv4_irq` delayed by one cycle.
- `rx_data_udp` input, 1 bit: a UDP byte is present on `rx_data`. A low cycle marks a frame boundary.
- `rx_data` input, OCT bits: UDP datagram byte stream, header first.
- `rx_src_port` output, 16 bits: source port of the current datagram.
- `rx_dst_port` output, 16 bits: destination port of the current datagram.
- `rx_udp_len` output, 16 bits: UDP length field of the current datagram.
- `rx_payload_valid` output, 1 bit: `rx_payload_data` carries a payload byte this cycle.
- `rx_payload_data` output, OCT bits: payload byte.
- `rx_payload_last` output, 1 bit: final payload byte; qualified by `rx_payload_valid`.
- `rx_udp_err` output, 1 bit: one-cycle error pulse.

## Operation
**States:** S_SRC_PORT, S_DST_PORT, S_LEN, S_CSUM, S_DATA, S_DROP.
- The state register starts in S_SRC_PORT with the 2-bit byte counter `cnt` at 0.

**Header states (S_SRC_PORT, S_DST_PORT, S_LEN, S_CSUM):**
- Each state consumes 2 bytes, MSB first, shifted into its 16-bit field.
- On `cnt==1` the state advances and `cnt` is cleared; otherwise `cnt` increments.
- The checksum is captured internally and not verified.

**Leaving S_LEN** (full length L = {hi, rx_data}):
- L < 8: pulse `rx_udp_err`, go to S_DROP.
- Port mismatch (`udp_port != 0` and `rx_dst_port != udp_port`): go to S_DROP, no error.
- Otherwise load the 16-bit remaining counter `rem = L - 8` and continue to S_CSUM.

**Leaving S_CSUM:**
- `rem == 0`: go to S_DROP. This is a valid empty datagram with no payload beats and no error.
- `rem != 0`: go to S_DATA.

**S_DATA:**
- Each input byte is registered to `rx_payload_data` with `rx_payload_valid=1`, and `rem` decrements.
- When `rem==1`, also assert `rx_payload_last=1` and go to S_DROP.

**S_DROP:** discard all bytes until `rx_data_udp` is low. This also discards Ethernet padding/FCS beyond L.

**Frame boundary** (any cycle with `rx_data_udp=0`):
- State returns to S_SRC_PORT and `cnt` clears.
- Pulse `rx_udp_err` if truncation occurred, i.e. the block was in:
  - S_SRC_PORT with `cnt!=0`, or
  - S_DST_PORT, S_LEN or S_CSUM, or
  - S_DATA with `rem!=0`.
- No `rx_payload_last` is emitted for a truncated datagram.

**Enable:**
- `func_en=0`: state, counters and header fields hold; `rx_payload_valid`, `rx_payload_last`, `rx_udp_err` and `rx_udp_irq` are driven to 0.
- Bytes presented while `func_en=0` are ignored.

## Timing
**Reset values:** all outputs 0, state S_SRC_PORT, `cnt=0`, `rem=0`.

**Latency:**
- A payload byte on `rx_data` in cycle n appears on `rx_payload_data`/`rx_payload_valid` in cycle n+1.
- `rx_udp_irq` lags `rx_ipv4_irq` by 1 cycle.

**Output behaviour:**
- `rx_payload_valid`, `rx_payload_last` and `rx_udp_err` are single-cycle registered pulses, cleared in every cycle not explicitly asserting them.
- `rx_src_port`, `rx_dst_port` and `rx_udp_len` update as bytes arrive and are stable from the first payload beat until the next datagram's header.
- There is no backpressure; the consumer must accept one byte per cycle.

**Corner cases:**
- Simultaneous last byte and boundary: a byte with `rem==1` is followed by `rx_data_udp=0` in the next cycle. No error is raised, because the state is already S_DROP.
- Reset mid-datagram: all outputs clear in the next cycle. The next accepted datagram starts parsing only after a boundary cycle.
- Arithmetic: `rem` is 16 bits and never wraps, because L ≥ 8 is checked before the load.

## Test plan
- **Accepted datagram:** `udp_port=16'h1234`; bytes `04 D2 12 34 00 0C 00 00 DE AD BE EF`, then `rx_data_udp=0`.
  - 4 valid beats `DE AD BE EF`, each 1 cycle after input.
  - `rx_payload_last` on `EF`.
  - `rx_src_port=16'h04D2`, `rx_udp_len=16'h000C`, no error.
- **Port mismatch:** same frame with `udp_port=16'h1235` → no valid beats, no error. With `udp_port=0` → accepted.
- **Padding trimmed:** `udp_len=16'h000A` with payload `11 22` followed by 20 padding bytes → exactly 2 beats, last on `22`.
- **Truncation:** `udp_len=16'h0010`, only 3 payload bytes, then boundary → 3 beats, no last, `rx_udp_err` pulses 1 cycle.
- **Bad length:** `udp_len=16'h0005` → error pulse at the cycle after the second length byte, no beats.
- **Enable, IRQ and reset:**
  - Toggling `func_en` low mid-payload pauses the stream and resumes it without lost or duplicated bytes.
  - A pulse on `rx_ipv4_irq` appears on `rx_udp_irq` 1 cycle later.
  - Asserting `rst` mid-datagram clears all outputs in the next cycle.

Source files
------------

// File: rtl/rx_udp.sv
// rx_udp: UDP receive stage behind the IPv4 receiver.
// Parses the 8-byte UDP header, filters on destination port and forwards the
// payload as a valid/last byte stream trimmed to the UDP length field.
module rx_udp #(
   parameter int OCT = 8
) (
   input  logic           RX_CLK,
   input  logic           rst,
   input  logic           func_en,
   input  logic [15:0]    udp_port,
   input  logic           rx_ipv4_irq,
   output logic           rx_udp_irq,
   input  logic           rx_data_udp,
   input  logic [OCT-1:0] rx_data,
   output logic [15:0]    rx_src_port,
   output logic [15:0]    rx_dst_port,
   output logic [15:0]    rx_udp_len,
   output logic           rx_payload_valid,
   output logic [OCT-1:0] rx_payload_data,
   output logic           rx_payload_last,
   output logic           rx_udp_err
);

   typedef enum logic [2:0] {
      S_SRC_PORT,
      S_DST_PORT,
      S_LEN,
      S_CSUM,
      S_DATA,
      S_DROP
   } state_t;

   state_t         state_q, state_d;
   logic [1:0]     cnt_q, cnt_d;
   logic [15:0]    rem_q, rem_d;
   logic [15:0]    src_q, src_d;
   logic [15:0]    dst_q, dst_d;
   logic [15:0]    len_q, len_d;
   logic [15:0]    csum_q, csum_d;
   // After reset the stream position is unknown, so parsing restarts only
   // once a frame boundary has been seen.
   logic           wait_bnd_q, wait_bnd_d;
   logic           pv_q, pv_d;
   logic [OCT-1:0] pd_q, pd_d;
   logic           pl_q, pl_d;
   logic           err_q, err_d;
   logic           irq_q, irq_d;

   logic [7:0]     byte_in;
   logic           hdr_done;

   assign byte_in  = rx_data[7:0];
   assign hdr_done = (cnt_q == 2'd1);

   // Insert the incoming header byte into a 16-bit field, MSB byte first.
   function automatic logic [15:0] field_ins(input logic [15:0] field,
                                             input logic [7:0]  b,
                                             input logic [1:0]  cnt);
      if (cnt == 2'd0)
         field_ins = {b, field[7:0]};
      else
         field_ins = {field[15:8], b};
   endfunction

   // Next-state, header capture, payload forwarding and error detection.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      rem_d      = rem_q;
      src_d      = src_q;
      dst_d      = dst_q;
      len_d      = len_q;
      csum_d     = csum_q;
      wait_bnd_d = wait_bnd_q;
      pv_d       = 1'b0;
      pd_d       = pd_q;
      pl_d       = 1'b0;
      err_d      = 1'b0;
      irq_d      = 1'b0;

      if (func_en) begin
         irq_d = rx_ipv4_irq;

         if (!rx_data_udp) begin
            // Frame boundary: resynchronise, flag a datagram cut short.
            wait_bnd_d = 1'b0;
            state_d    = S_SRC_PORT;
            cnt_d      = 2'd0;
            if (!wait_bnd_q) begin
               case (state_q)
                  S_SRC_PORT: err_d = (cnt_q != 2'd0);
                  S_DST_PORT,
                  S_LEN,
                  S_CSUM:     err_d = 1'b1;
                  S_DATA:     err_d = (rem_q != 16'd0);
                  default:    err_d = 1'b0;
               endcase
            end
         end else if (!wait_bnd_q) begin
            case (state_q)
               S_SRC_PORT: begin
                  src_d = field_ins(src_q, byte_in, cnt_q);
                  cnt_d = hdr_done ? 2'd0 : cnt_q + 2'd1;
                  if (hdr_done)
                     state_d = S_DST_PORT;
               end

               S_DST_PORT: begin
                  dst_d = field_ins(dst_q, byte_in, cnt_q);
                  cnt_d = hdr_done ? 2'd0 : cnt_q + 2'd1;
                  if (hdr_done)
                     state_d = S_LEN;
               end

               S_LEN: begin
                  len_d = field_ins(len_q, byte_in, cnt_q);
                  cnt_d = hdr_done ? 2'd0 : cnt_q + 2'd1;
                  if (hdr_done) begin
                     // Length covers the 8 header bytes; anything shorter is
                     // malformed. Checking first keeps rem from wrapping.
                     if (len_d < 16'd8) begin
                        err_d   = 1'b1;
                        state_d = S_DROP;
                     end else if ((udp_port != 16'h0000) && (dst_q != udp_port)) begin
                        state_d = S_DROP;
                     end else begin
                        rem_d   = len_d - 16'd8;
                        state_d = S_CSUM;
                     end
                  end
               end

               S_CSUM: begin
                  // Checksum is kept but not verified.
                  csum_d = field_ins(csum_q, byte_in, cnt_q);
                  cnt_d  = hdr_done ? 2'd0 : cnt_q + 2'd1;
                  if (hdr_done)
                     state_d = (rem_q == 16'd0) ? S_DROP : S_DATA;
               end

               S_DATA: begin
                  pv_d  = 1'b1;
                  pd_d  = rx_data;
                  rem_d = rem_q - 16'd1;
                  if (rem_q == 16'd1) begin
                     pl_d    = 1'b1;
                     state_d = S_DROP;
                  end
               end

               default: begin
                  // S_DROP: swallow padding/FCS until the boundary.
                  state_d = S_DROP;
               end
            endcase
         end
      end
   end

   // State, header fields and registered output pulses.
   always_ff @(posedge RX_CLK) begin
      if (rst) begin
         state_q    <= S_SRC_PORT;
         cnt_q      <= 2'd0;
         rem_q      <= 16'd0;
         src_q      <= 16'd0;
         dst_q      <= 16'd0;
         len_q      <= 16'd0;
         csum_q     <= 16'd0;
         wait_bnd_q <= 1'b1;
         pv_q       <= 1'b0;
         pd_q       <= '0;
         pl_q       <= 1'b0;
         err_q      <= 1'b0;
         irq_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rem_q      <= rem_d;
         src_q      <= src_d;
         dst_q      <= dst_d;
         len_q      <= len_d;
         csum_q     <= csum_d;
         wait_bnd_q <= wait_bnd_d;
         pv_q       <= pv_d;
         pd_q       <= pd_d;
         pl_q       <= pl_d;
         err_q      <= err_d;
         irq_q      <= irq_d;
      end
   end

   assign rx_src_port      = src_q;
   assign rx_dst_port      = dst_q;
   assign rx_udp_len       = len_q;
   assign rx_payload_valid = pv_q;
   assign rx_payload_data  = pd_q;
   assign rx_payload_last  = pl_q;
   assign rx_udp_err       = err_q;
   assign rx_udp_irq       = irq_q;

endmodule
